// File: rtl/memc_arbiter_if.sv
// memc_arbiter bus bundle: requester handshake, memory-controller command/status.
// Also carries the shared command/status payload package.

package memc_arbiter_pkg;

  localparam int unsigned ADDR_W       = 32;
  localparam int unsigned CACHE_ADDR_W = 12;
  localparam int unsigned RQ_ID_W      = 4;
  localparam int unsigned RESULT_W     = 32;

  typedef enum logic [2:0] {
    MEMC_NONE            = 3'd0,
    MEMC_CP_CACHE_TO_EXT = 3'd1,
    MEMC_CP_EXT_TO_CACHE = 3'd2,
    MEMC_READ_BYTE       = 3'd3,
    MEMC_WRITE_BYTE      = 3'd4,
    MEMC_PAGE_WALK       = 3'd5
  } memc_cmd_e;

  // Command towards the memory controller
  typedef struct packed {
    memc_cmd_e                 cmd;
    logic [ADDR_W-1:0]         extAddr;
    logic [CACHE_ADDR_W-1:0]   cacheAddr;
    logic [RQ_ID_W-1:0]        rqID;
  } ctrl_memc_t;

  // Status returned by the memory controller
  typedef struct packed {
    logic                      busy;
    logic [RQ_ID_W-1:0]        rqID;
    logic [RESULT_W-1:0]       result;
    logic                      isSuperPage;
  } stat_memc_t;

endpackage

interface memc_arbiter_if #(
  parameter int unsigned NUM_RQ = 3
);
  import memc_arbiter_pkg::*;

  logic       [NUM_RQ-1:0] IN_req;
  ctrl_memc_t [NUM_RQ-1:0] IN_ctrl;
  logic       [NUM_RQ-1:0] OUT_grant;
  logic       [NUM_RQ-1:0] OUT_done;
  logic       [NUM_RQ-1:0] OUT_err;
  logic [RESULT_W-1:0]     OUT_result;
  logic                    OUT_resultSuper;
  ctrl_memc_t              OUT_memc;
  stat_memc_t              IN_memcStat;
  logic                    OUT_busy;

  // Arbiter side
  modport slave (
    input  IN_req, IN_ctrl, IN_memcStat,
    output OUT_grant, OUT_done, OUT_err, OUT_result, OUT_resultSuper,
           OUT_memc, OUT_busy
  );

  // Requester / memory-controller side
  modport master (
    output IN_req, IN_ctrl, IN_memcStat,
    input  OUT_grant, OUT_done, OUT_err, OUT_result, OUT_resultSuper,
           OUT_memc, OUT_busy
  );

endinterface

// File: rtl/memc_arbiter.sv
// memc_arbiter: single-outstanding arbiter in front of the memory controller.
// Port 0 (page walker) has absolute priority; ports 1..NUM_RQ-1 share round-robin.
// Optional acknowledge watchdog: define MEMC_ARB_TIMEOUT_EN.

module memc_arbiter
  import memc_arbiter_pkg::*;
#(
  parameter int unsigned NUM_RQ  = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  memc_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_RQ > 1) ? $clog2(NUM_RQ) : 1;
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  ctrl_memc_t           cmd_q, cmd_d;
  ctrl_memc_t           memc_q, memc_d;
  logic [NUM_RQ-1:0]    grant_q, grant_d;
  logic [NUM_RQ-1:0]    done_q, done_d;
  logic [RESULT_W-1:0]  result_q, result_d;
  logic                 super_q, super_d;
  logic                 busy_q, busy_d;
  logic [TO_W-1:0]      to_cnt_q, to_cnt_d;
`ifdef MEMC_ARB_TIMEOUT_EN
  logic [NUM_RQ-1:0]    err_q, err_d;
`endif

  logic [NUM_RQ-1:0]    valid;
  logic [IDX_W-1:0]     sel, sel_hi, sel_lo;
  logic                 hit_hi;
  logic                 any_valid;
  logic                 ack;

  // Request qualification and pick: port 0 first, else first client at/after ptr_q, else wrap
  always_comb begin
    valid     = '0;
    sel       = '0;
    sel_hi    = '0;
    sel_lo    = '0;
    hit_hi    = 1'b0;
    any_valid = 1'b0;
    for (int i = 0; i < int'(NUM_RQ); i++) begin
      valid[i] = bus.IN_req[i] && (bus.IN_ctrl[i].cmd != MEMC_NONE);
    end
    // Descending scan so the lowest qualifying index is the one left standing
    for (int i = int'(NUM_RQ) - 1; i >= 1; i--) begin
      if (valid[i]) begin
        sel_lo = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          sel_hi = IDX_W'(i);
          hit_hi = 1'b1;
        end
      end
    end
    if (valid[0]) begin
      sel = '0;
    end else if (hit_hi) begin
      sel = sel_hi;
    end else begin
      sel = sel_lo;
    end
    any_valid = |valid;
  end

  // Acknowledge: controller busy with our latched request id
  always_comb begin
    ack = bus.IN_memcStat.busy && (bus.IN_memcStat.rqID == cmd_q.rqID);
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cmd_d    = cmd_q;
    memc_d   = '0;
    grant_d  = '0;
    done_d   = '0;
    result_d = result_q;
    super_d  = super_q;
    to_cnt_d = to_cnt_q;
`ifdef MEMC_ARB_TIMEOUT_EN
    err_d    = '0;
`endif

    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (!bus.IN_memcStat.busy && any_valid) begin
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          cmd_d        = bus.IN_ctrl[sel];
          cmd_d.rqID   = RQ_ID_W'(sel);
          // Pointer only tracks the client ring; page-walk grants leave it alone
          if (sel != '0) begin
            ptr_d = (sel == IDX_W'(NUM_RQ - 1)) ? IDX_W'(1) : sel + IDX_W'(1);
          end
          state_d = ISSUE;
        end
      end

      ISSUE: begin
        if (ack) begin
          state_d = WAIT_DONE;
        end else begin
          memc_d = cmd_q;
          if (to_cnt_q != TO_W'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
`ifdef MEMC_ARB_TIMEOUT_EN
          if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
            memc_d         = '0;
            err_d[owner_q] = 1'b1;
            state_d        = IDLE;
          end
`endif
        end
      end

      WAIT_DONE: begin
        if (!bus.IN_memcStat.busy) begin
          done_d[owner_q] = 1'b1;
          result_d        = bus.IN_memcStat.result;
          super_d         = bus.IN_memcStat.isSuperPage;
          state_d         = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any outstanding command silently
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= IDX_W'(1);
      cmd_q    <= '0;
      memc_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      result_q <= '0;
      super_q  <= 1'b0;
      busy_q   <= 1'b0;
      to_cnt_q <= '0;
`ifdef MEMC_ARB_TIMEOUT_EN
      err_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cmd_q    <= cmd_d;
      memc_q   <= memc_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      result_q <= result_d;
      super_q  <= super_d;
      busy_q   <= busy_d;
      to_cnt_q <= to_cnt_d;
`ifdef MEMC_ARB_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  assign bus.OUT_grant       = grant_q;
  assign bus.OUT_done        = done_q;
  assign bus.OUT_result      = result_q;
  assign bus.OUT_resultSuper = super_q;
  assign bus.OUT_memc        = memc_q;
  assign bus.OUT_busy        = busy_q;
`ifdef MEMC_ARB_TIMEOUT_EN
  assign bus.OUT_err         = err_q;
`else
  assign bus.OUT_err         = '0;
`endif

endmodule

// File: tb/tb_memc_arbiter.sv
// Scoreboard bench for memc_arbiter: stimulus pushes expected grant/issue/done/err
// events, a monitor pops and compares whenever the DUT pulses an output.

module tb_memc_arbiter;
  import memc_arbiter_pkg::*;

  localparam int unsigned NUM_RQ  = 3;
  localparam int unsigned TIMEOUT = 16;
  localparam int K_GRANT = 0;
  localparam int K_ISSUE = 1;
  localparam int K_DONE  = 2;
  localparam int K_ERR   = 3;

  typedef struct {
    int                  kind;
    int                  idx;
    ctrl_memc_t          cmd;
    logic [RESULT_W-1:0] res;
    logic                sup;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  memc_arbiter_if #(.NUM_RQ(NUM_RQ)) bus ();

  memc_arbiter #(.NUM_RQ(NUM_RQ), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int grant_cyc = 0;
  int done_seen = 0;
  ev_t exp_q[$];

  ctrl_memc_t          orig     [NUM_RQ];
  logic [RESULT_W-1:0] res_tbl  [NUM_RQ];
  logic                sup_tbl  [NUM_RQ];
  int                  rep      [NUM_RQ];
  int                  rearm_on [NUM_RQ];

  bit ack_en = 1'b1;
  int mc_lat = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard consumer for one observed DUT event
  task automatic observe(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d seen with empty scoreboard (t=%0t)", kind, $time);
      return;
    end
    e = exp_q.pop_front();
    check("event_kind", 64'(kind), 64'(e.kind));
    case (kind)
      K_GRANT: begin
        check("grant_onehot", 64'(bus.OUT_grant), 64'(NUM_RQ'(1) << e.idx));
        grant_cyc = cyc;
      end
      K_ISSUE: begin
        check("issue_cmd", 64'(bus.OUT_memc), 64'(e.cmd));
        check("issue_latency", 64'(cyc), 64'(grant_cyc + 1));
      end
      K_DONE: begin
        check("done_onehot", 64'(bus.OUT_done), 64'(NUM_RQ'(1) << e.idx));
        check("done_result", 64'(bus.OUT_result), 64'(e.res));
        check("done_super", 64'(bus.OUT_resultSuper), 64'(e.sup));
        done_seen++;
      end
      default: begin
        check("err_onehot", 64'(bus.OUT_err), 64'(NUM_RQ'(1) << e.idx));
      end
    endcase
  endtask

  // Monitor: every pulse or new command on the bus is matched against the queue
  initial begin : monitor
    bit prev_none;
    prev_none = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (bus.OUT_grant != '0) observe(K_GRANT);
        if (bus.OUT_memc.cmd != MEMC_NONE && prev_none) observe(K_ISSUE);
        if (bus.OUT_done != '0) observe(K_DONE);
        if (bus.OUT_err != '0) observe(K_ERR);
      end
      prev_none = (bus.OUT_memc.cmd == MEMC_NONE);
    end
  end

  // Memory-controller model: accept a command, stay busy mc_lat cycles, then return a result
  initial begin : mc_model
    int  cnt;
    int  cur;
    bit  ack_chk;
    cnt = 0;
    cur = 0;
    ack_chk = 1'b0;
    bus.IN_memcStat = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt = 0;
        ack_chk = 1'b0;
        bus.IN_memcStat = '0;
      end else begin
        if (ack_chk) begin
          check("cmd_drop_after_ack", 64'(bus.OUT_memc.cmd), 64'(MEMC_NONE));
          ack_chk = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bus.IN_memcStat.busy        = 1'b0;
            bus.IN_memcStat.result      = (cur < int'(NUM_RQ)) ? res_tbl[cur] : '0;
            bus.IN_memcStat.isSuperPage = (cur < int'(NUM_RQ)) ? sup_tbl[cur] : 1'b0;
          end
        end else if (ack_en && bus.OUT_memc.cmd != MEMC_NONE) begin
          bus.IN_memcStat.busy        = 1'b1;
          bus.IN_memcStat.rqID        = bus.OUT_memc.rqID;
          bus.IN_memcStat.result      = '0;
          bus.IN_memcStat.isSuperPage = 1'b0;
          cur     = int'(bus.OUT_memc.rqID);
          cnt     = mc_lat;
          ack_chk = 1'b1;
        end
      end
    end
  end

  // One cycle of requester behaviour: drop and scramble on grant, re-arm scheduled ports
  task automatic step();
    @(negedge clk);
    #1;
    for (int j = 0; j < int'(NUM_RQ); j++) begin
      if (bus.OUT_grant[j]) begin
        bus.IN_req[j]             = 1'b0;
        bus.IN_ctrl[j].cmd        = MEMC_CP_CACHE_TO_EXT;
        bus.IN_ctrl[j].extAddr    = 32'hBAD0_0000;
        for (int i = 0; i < int'(NUM_RQ); i++) begin
          if (rep[i] > 0 && rearm_on[i] == j) begin
            rep[i]--;
            bus.IN_req[i]  = 1'b1;
            bus.IN_ctrl[i] = orig[i];
          end
        end
      end
    end
  endtask

  task automatic setup_port(input int i, input memc_cmd_e cmd, input logic [31:0] addr,
                            input logic [RESULT_W-1:0] res, input logic sup);
    orig[i].cmd       = cmd;
    orig[i].extAddr   = addr;
    orig[i].cacheAddr = CACHE_ADDR_W'(addr >> 4);
    orig[i].rqID      = 4'hF;
    res_tbl[i]        = res;
    sup_tbl[i]        = sup;
  endtask

  task automatic push_txn(input int i, input bit with_done);
    ev_t e;
    e.kind = K_GRANT;
    e.idx  = i;
    e.cmd  = '0;
    e.res  = '0;
    e.sup  = 1'b0;
    exp_q.push_back(e);
    e.kind = K_ISSUE;
    e.cmd  = orig[i];
    e.cmd.rqID = RQ_ID_W'(i);
    exp_q.push_back(e);
    if (with_done) begin
      e.kind = K_DONE;
      e.res  = res_tbl[i];
      e.sup  = sup_tbl[i];
      exp_q.push_back(e);
    end
  endtask

  task automatic raise(input int i);
    bus.IN_ctrl[i] = orig[i];
    bus.IN_req[i]  = 1'b1;
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_grant"},  64'(bus.OUT_grant), 64'(0));
    check({pre, "_done"},   64'(bus.OUT_done), 64'(0));
    check({pre, "_err"},    64'(bus.OUT_err), 64'(0));
    check({pre, "_result"}, 64'(bus.OUT_result), 64'(0));
    check({pre, "_super"},  64'(bus.OUT_resultSuper), 64'(0));
    check({pre, "_busy"},   64'(bus.OUT_busy), 64'(0));
    check({pre, "_memc"},   64'(bus.OUT_memc), 64'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_zero("reset");
    bus.IN_req  = '0;
    bus.IN_ctrl = '0;
    for (int i = 0; i < int'(NUM_RQ); i++) begin
      rep[i]      = 0;
      rearm_on[i] = 0;
    end
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while ((exp_q.size() != 0 || bus.OUT_busy) && k < max);
    if (exp_q.size() != 0 || bus.OUT_busy) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d events still pending, busy=%0b after %0d cycles",
               exp_q.size(), bus.OUT_busy, max);
    end
  endtask

  task automatic wait_grant(input int i, input int max);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!bus.OUT_grant[i] && k < max);
    check("grant_seen", 64'(bus.OUT_grant[i]), 64'(1));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "global timeout");
  end

  initial begin : stimulus
    int d0;
    bus.IN_req  = '0;
    bus.IN_ctrl = '0;
    for (int i = 0; i < int'(NUM_RQ); i++) begin
      rep[i] = 0;
      rearm_on[i] = 0;
      res_tbl[i] = '0;
      sup_tbl[i] = 1'b0;
      orig[i] = '0;
    end
    repeat (2) @(negedge clk);
    do_reset();

    // Single client request, then a MEMC_NONE request that must be ignored
    setup_port(1, MEMC_CP_EXT_TO_CACHE, 32'h0000_0100, 32'h1111_0001, 1'b0);
    push_txn(1, 1'b1);
    raise(1);
    wait_idle(60);
    bus.IN_ctrl[2] = '0;
    bus.IN_req[2]  = 1'b1;
    repeat (6) step();
    check("none_ignored_busy", 64'(bus.OUT_busy), 64'(0));
    bus.IN_req[2]  = 1'b0;

    // Page-walk priority: order 0,1 then port 0 (re-armed on port 1 grant) before 2
    do_reset();
    setup_port(0, MEMC_PAGE_WALK,       32'h0000_2000, 32'hDEAD_B000, 1'b1);
    setup_port(1, MEMC_CP_EXT_TO_CACHE, 32'h0000_0300, 32'h1111_0011, 1'b0);
    setup_port(2, MEMC_CP_CACHE_TO_EXT, 32'h0000_0400, 32'h2222_0022, 1'b0);
    push_txn(0, 1'b1);
    push_txn(1, 1'b1);
    push_txn(0, 1'b1);
    push_txn(2, 1'b1);
    rep[0] = 1;
    rearm_on[0] = 1;
    raise(0);
    raise(1);
    raise(2);
    wait_idle(200);
    check("last_result_port2", 64'(bus.OUT_result), 64'(32'h2222_0022));

    // Round-robin fairness between clients 1 and 2
    do_reset();
    setup_port(1, MEMC_READ_BYTE,  32'h0000_0500, 32'h0000_0A01, 1'b0);
    setup_port(2, MEMC_WRITE_BYTE, 32'h0000_0600, 32'h0000_0B02, 1'b1);
    push_txn(1, 1'b1);
    push_txn(2, 1'b1);
    push_txn(1, 1'b1);
    push_txn(2, 1'b1);
    rep[1] = 1;
    rearm_on[1] = 1;
    rep[2] = 1;
    rearm_on[2] = 2;
    raise(1);
    raise(2);
    wait_idle(200);

    // Acknowledge never arrives
    do_reset();
    ack_en = 1'b0;
    setup_port(1, MEMC_CP_EXT_TO_CACHE, 32'h0000_0700, 32'h0, 1'b0);
    push_txn(1, 1'b0);
`ifdef MEMC_ARB_TIMEOUT_EN
    begin
      ev_t e;
      e.kind = K_ERR;
      e.idx  = 1;
      e.cmd  = '0;
      e.res  = '0;
      e.sup  = 1'b0;
      exp_q.push_back(e);
    end
`endif
    raise(1);
    wait_grant(1, 20);
    repeat (15) step();
    check("err_before_limit", 64'(bus.OUT_err), 64'(0));
    check("busy_before_limit", 64'(bus.OUT_busy), 64'(1));
    step();
`ifdef MEMC_ARB_TIMEOUT_EN
    check("err_at_limit", 64'(bus.OUT_err), 64'(3'b010));
    check("idle_after_err", 64'(bus.OUT_busy), 64'(0));
    check("memc_none_after_err", 64'(bus.OUT_memc.cmd), 64'(MEMC_NONE));
`else
    repeat (84) step();
    check("still_issue_busy", 64'(bus.OUT_busy), 64'(1));
    check("still_issue_cmd", 64'(bus.OUT_memc.cmd), 64'(MEMC_CP_EXT_TO_CACHE));
    check("err_tied_low", 64'(bus.OUT_err), 64'(0));
`endif
    check("sb_empty_timeout", 64'(exp_q.size()), 64'(0));
    ack_en = 1'b1;

    // Reset while waiting for completion abandons the command
    do_reset();
    mc_lat = 20;
    setup_port(2, MEMC_CP_CACHE_TO_EXT, 32'h0000_0800, 32'h3333_0033, 1'b0);
    push_txn(2, 1'b0);
    raise(2);
    wait_grant(2, 20);
    repeat (5) step();
    check("busy_in_wait_done", 64'(bus.OUT_busy), 64'(1));
    check("memc_none_in_wait", 64'(bus.OUT_memc.cmd), 64'(MEMC_NONE));
    d0 = done_seen;
    #2 rst = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    repeat (30) step();
    check("no_done_after_reset", 64'(done_seen), 64'(d0));
    check("idle_after_reset", 64'(bus.OUT_busy), 64'(0));
    mc_lat = 3;

    check("sb_empty_final", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/memc_arbiter.md
MEMC_ARBITER -- requirements
Module: memc_arbiter

Interface
REQ-001 SHALL have parameter NUM_RQ, default 3, number of requester ports; port 0 is the page walker, ports 1..NUM_RQ-1 are cache refill/writeback clients.
REQ-002 SHALL have parameter TIMEOUT, default 16, the cycle limit for memory-controller acknowledge (used only with REQ-027).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port IN_req, input, NUM_RQ, per-requester request valid.
REQ-006 SHALL have port IN_ctrl, input, NUM_RQ x CTRL_MemC, per-requester command; the rqID field is ignored.
REQ-007 SHALL have port OUT_grant, output, NUM_RQ, one-hot one-cycle pulse marking request acceptance.
REQ-008 SHALL have port OUT_done, output, NUM_RQ, one-hot one-cycle pulse marking completion.
REQ-009 SHALL have port OUT_err, output, NUM_RQ, one-hot one-cycle pulse marking acknowledge timeout.
REQ-010 SHALL have port OUT_result, output, 32, the result word of the last completed command.
REQ-011 SHALL have port OUT_resultSuper, output, 1, the isSuperPage flag of the last completed command.
REQ-012 SHALL have port OUT_memc, output, CTRL_MemC, the command to the memory controller.
REQ-013 SHALL have port IN_memcStat, input, STAT_MemC, the memory-controller status.
REQ-014 SHALL have port OUT_busy, output, 1, high whenever the FSM is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, ISSUE, WAIT_DONE, with exactly one command outstanding.
REQ-016 In IDLE with IN_memcStat.busy=0, SHALL select a requester with IN_req=1 and IN_ctrl.cmd!=MEMC_NONE, pulse its OUT_grant, latch its IN_ctrl with rqID=index, and enter ISSUE.
REQ-017 Requests with cmd=MEMC_NONE SHALL be ignored; no grant is given.
REQ-018 Priority SHALL be: port 0 always wins; among ports 1..NUM_RQ-1, round-robin with a pointer starting at 1 after reset and moving to (granted index+1), wrapping to 1.
REQ-019 In ISSUE, OUT_memc SHALL drive the latched command, starting the cycle after the grant; on IN_memcStat.busy=1 with rqID equal to the latched rqID, SHALL drive OUT_memc.cmd=MEMC_NONE from the next cycle and enter WAIT_DONE.
REQ-020 In WAIT_DONE, on IN_memcStat.busy=0, SHALL pulse OUT_done[owner], capture OUT_result and OUT_resultSuper from IN_memcStat.result and isSuperPage in the same edge, and enter IDLE.
REQ-021 After a completion, no grant SHALL occur in the same cycle; the earliest next grant is one cycle after the OUT_done pulse.
REQ-022 A requester SHALL hold IN_req and IN_ctrl stable until its grant; changes to IN_ctrl after the grant SHALL have no effect.
REQ-023 OUT_memc.cmd SHALL be MEMC_NONE in every state except ISSUE.

Reset
REQ-024 While rst=0, SHALL hold: FSM=IDLE, OUT_memc all zero (cmd=MEMC_NONE), OUT_grant/OUT_done/OUT_err=0, OUT_result=0, OUT_resultSuper=0, OUT_busy=0, round-robin pointer=1, timeout counter=0.
REQ-025 Reset asserted mid-operation SHALL abandon the outstanding command without a done or err pulse.

Configuration
REQ-026 Macro MEMC_ARB_TIMEOUT_EN SHALL select the acknowledge watchdog.
REQ-027 With MEMC_ARB_TIMEOUT_EN defined: a counter clears on entry to ISSUE and increments each ISSUE cycle; if it reaches TIMEOUT without acknowledge, SHALL pulse OUT_err[owner], drive cmd=MEMC_NONE, and return to IDLE with no OUT_done.
REQ-028 Without MEMC_ARB_TIMEOUT_EN: ISSUE SHALL wait indefinitely, and OUT_err SHALL be tied to 0.

Verification
REQ-029 Single request: IN_req[1]=1 with cmd=MEMC_CP_EXT_TO_CACHE, extAddr=0x100 -> OUT_grant[1] at cycle N; OUT_memc.cmd=MEMC_CP_EXT_TO_CACHE, rqID=1 at N+1; stat busy=1 rqID=1 -> cmd=MEMC_NONE; busy=0 -> OUT_done[1] pulse.
REQ-030 Page-walk priority: IN_req[0..2] all set -> grant order 0, 1, 2; port 0 re-asserted after its done -> served before port 2.
REQ-031 Round-robin fairness: ports 1 and 2 continuously requesting -> grants alternate 1, 2, 1, 2.
REQ-032 Result capture: page walk completes with result=0xDEADB000, isSuperPage=1 -> OUT_result=0xDEADB000, OUT_resultSuper=1 in the OUT_done[0] cycle.
REQ-033 Timeout (MEMC_ARB_TIMEOUT_EN, TIMEOUT=16): stat busy held 0 after grant -> OUT_err pulse 16 cycles after ISSUE entry, FSM IDLE; without the macro, still in ISSUE at cycle 100.
REQ-034 Reset mid-WAIT_DONE: drive rst=0 -> all outputs zero asynchronously; no OUT_done after rst=1.
